block_fill_responder: RTL and testbench
=======================================

# block_fill_responder

Block-fill responder sitting above the instruction cache. It accepts the cache's level-held block request (block-aligned address plus request strobe) and fetches the 16 words of the 512-bit block one at a time from a word-wide backing-memory port. It then returns the whole block with its address in a one-cycle valid pulse. It is the responding end of the cache's higher-level request interface.

## Interface
- BLOCK_BITS, 512, block size in bits; fixed at 16 × 32-bit words, other values unsupported
- WORD_BITS, 32, backing-memory word width

- clk_i  in  1  clock, all state updates on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- req_valid_i  in  1  block request from cache, held high until served
- req_addr_i  in  32  requested block address; bits [5:0] ignored
- rsp_valid_o  out  1  one-cycle pulse: block data and address valid
- rsp_addr_o  out  32  returned block address, bits [5:0] = 0
- rsp_data_o  out  512  block; word j at bits [32j+31:32j] = mem[base+4j]
- mem_req_o  out  1  word read request to backing memory
- mem_addr_o  out  32  word address, base + 4×count
- mem_ack_i  in  1  backing memory: mem_rdata_i valid, request consumed
- mem_rdata_i  in  32  read word

## Operation
- States: IDLE, FETCH, RESPOND.
- IDLE:
  - On req_valid_i high at an edge: latch base = {req_addr_i[31:6], 6'h00}, clear count to 0, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - mem_req_o = 1 and mem_addr_o = base + {count, 2'b00}.
  - On an edge with mem_ack_i high: write mem_rdata_i into data word[count] and increment count.
  - When count == 15 and ack: go to RESPOND.
  - mem_req_o stays high through stalls (ack low). Ack may arrive in the same cycle as the request.
- RESPOND:
  - rsp_valid_o = 1 for exactly one cycle, then go to IDLE.
  - req_valid_i is ignored in RESPOND; the cache drops it during the pulse.
- rsp_addr_o and rsp_data_o are registers:
  - rsp_addr_o updates when a request is accepted.
  - rsp_data_o is written word by word during FETCH.
  - Both hold their value after RESPOND until the next fetch overwrites them.
  - Only their value during the rsp_valid_o cycle is defined.
- req_valid_i dropping mid-FETCH does not abort. The fetch completes and rsp_valid_o still pulses.
- req_addr_i changes after acceptance are ignored.
- count is 4 bits and never wraps within a fetch. Address arithmetic is modulo 2^32 but stays within the 64-byte block.
- Reset (asynchronous, any state, including mid-FETCH):
  - State goes to IDLE; count, base and the data register clear to 0.
  - All outputs go to 0: rsp_valid_o, mem_req_o, rsp_addr_o, rsp_data_o, mem_addr_o.
  - The reuse entry is invalidated.
  - An in-flight memory read is abandoned; a late ack after reset is ignored in IDLE.

## Timing
- Edge E0 samples req_valid_i high in IDLE. FETCH occupies the cycles after E0.
- With mem_ack_i held high, edges E1..E16 capture words 0..15. rsp_valid_o is high between E16 and E17.
- Miss latency is 17 cycles plus one cycle per ack-low stall cycle in FETCH.
- Back in IDLE after E17, the earliest next request is sampled at E18.
- mem_req_o and mem_addr_o are decoded from state and count only; there is no combinational path from req_* to mem_*.

## Configuration
- BLOCK_FILL_REUSE_EN defined:
  - Adds a one-entry buffer: a reuse tag (base[31:6]) plus a valid bit, set on every completed fetch.
  - In IDLE, a request whose base matches a valid tag goes straight to RESPOND with no memory traffic. rsp_valid_o is high between E0 and E1 (latency 1), with rsp_data_o unchanged.
- BLOCK_FILL_REUSE_EN undefined: no buffer; every request performs a full 16-word fetch.

## Test plan
- Reset and basic fetch:
  - Stimulus: assert reset, release; memory returns addr^32'hA5A5_0000 with ack always high; request 0x0000_1234.
  - Required: all outputs 0 during reset. mem_addr_o steps 0x1200..0x123C. rsp_valid_o is a single pulse 17 cycles after the request, with rsp_addr_o = 0x0000_1200 and word 3 = 0xA5A5_120C.
- Memory stalls: ack low for 2 cycles before each word -> rsp_valid_o at 17+32 = 49 cycles; mem_addr_o is stable during each stall.
- Request protocol:
  - Requester drops req_valid_i in the pulse cycle -> exactly one rsp_valid_o, no second fetch.
  - Request 0x40 held through the pulse and beyond -> a second fetch starts at E18.
- Reset mid-operation: reset asserted at word 7 -> asynchronous return to IDLE with all outputs 0. A later request for 0x80 fetches a full block from word 0.
- Reuse with BLOCK_FILL_REUSE_EN: request 0x1200, then request 0x1230 -> the second response arrives after 1 cycle with no mem_req_o.
- Reuse without BLOCK_FILL_REUSE_EN: the same sequence -> the second request performs a full 17-cycle fetch.
- Mismatched base with BLOCK_FILL_REUSE_EN: after 0x1200, a request for 0x1240 -> full fetch, and the tag updates.

Source files
------------

// File: rtl/block_fill_responder_if.sv
// Cache-to-responder request/response bundle plus the word-wide backing-memory port.
// The slave modport is the block-fill responder; master is the cache/memory side.
interface block_fill_responder_if #(
  parameter int BLOCK_BITS = 512,
  parameter int WORD_BITS  = 32
);
  logic                  req_valid;
  logic [31:0]           req_addr;
  logic                  rsp_valid;
  logic [31:0]           rsp_addr;
  logic [BLOCK_BITS-1:0] rsp_data;
  logic                  mem_req;
  logic [31:0]           mem_addr;
  logic                  mem_ack;
  logic [WORD_BITS-1:0]  mem_rdata;

  modport master (
    output req_valid,
    output req_addr,
    output mem_ack,
    output mem_rdata,
    input  rsp_valid,
    input  rsp_addr,
    input  rsp_data,
    input  mem_req,
    input  mem_addr
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  mem_ack,
    input  mem_rdata,
    output rsp_valid,
    output rsp_addr,
    output rsp_data,
    output mem_req,
    output mem_addr
  );
endinterface

// File: rtl/block_fill_responder.sv
// Block-fill responder: fetches a 16-word block word by word and returns it in one pulse.
// Optional one-entry reuse buffer enabled by defining BLOCK_FILL_REUSE_EN.
module block_fill_responder #(
  parameter int BLOCK_BITS = 512,
  parameter int WORD_BITS  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  block_fill_responder_if.slave      bus
);

  localparam int         NUM_WORDS = BLOCK_BITS / WORD_BITS;
  localparam logic [3:0] LAST_WORD = 4'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_RESPOND
  } state_t;

  state_t      state_reg;
  logic [3:0]  count_reg;
  logic [31:0] base_reg;
  logic        mem_req_reg;
  logic [31:0] mem_addr_reg;
  logic        rsp_valid_reg;

  logic [31:0] req_base;
  logic        word_we;
  logic        fetch_done;
  logic        reuse_hit;
  logic        unused_req_offset;

  assign req_base          = {bus.req_addr[31:6], 6'h00};
  assign unused_req_offset = ^bus.req_addr[5:0];
  assign word_we           = (state_reg == ST_FETCH) && bus.mem_ack;
  assign fetch_done        = word_we && (count_reg == LAST_WORD);

  // Control FSM; memory-side outputs are registered so req_* never reaches mem_* combinationally.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg     <= ST_IDLE;
      count_reg     <= 4'd0;
      base_reg      <= 32'd0;
      mem_req_reg   <= 1'b0;
      mem_addr_reg  <= 32'd0;
      rsp_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          rsp_valid_reg <= 1'b0;
          if (bus.req_valid) begin
            base_reg  <= req_base;
            count_reg <= 4'd0;
            if (reuse_hit) begin
              state_reg     <= ST_RESPOND;
              rsp_valid_reg <= 1'b1;
            end else begin
              state_reg    <= ST_FETCH;
              mem_req_reg  <= 1'b1;
              mem_addr_reg <= req_base;
            end
          end
        end
        ST_FETCH: begin
          if (bus.mem_ack) begin
            if (count_reg == LAST_WORD) begin
              state_reg     <= ST_RESPOND;
              mem_req_reg   <= 1'b0;
              mem_addr_reg  <= 32'd0;
              rsp_valid_reg <= 1'b1;
            end else begin
              count_reg    <= count_reg + 4'd1;
              mem_addr_reg <= base_reg + {26'd0, count_reg + 4'd1, 2'b00};
            end
          end
        end
        ST_RESPOND: begin
          rsp_valid_reg <= 1'b0;
          state_reg     <= ST_IDLE;
        end
        default: begin
          state_reg     <= ST_IDLE;
          mem_req_reg   <= 1'b0;
          rsp_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // One register per word, written only when its index matches the acknowledged count.
  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      logic [WORD_BITS-1:0] word_reg;

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          word_reg <= '0;
        end else if (word_we && (count_reg == 4'(gi))) begin
          word_reg <= bus.mem_rdata;
        end
      end

      assign bus.rsp_data[gi*WORD_BITS +: WORD_BITS] = word_reg;
    end
  endgenerate

`ifdef BLOCK_FILL_REUSE_EN
  logic [25:0] reuse_tag_reg;
  logic        reuse_valid_reg;

  // The data register still holds the last fetched block, so a tag match can answer directly.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      reuse_tag_reg   <= 26'd0;
      reuse_valid_reg <= 1'b0;
    end else if (fetch_done) begin
      reuse_tag_reg   <= base_reg[31:6];
      reuse_valid_reg <= 1'b1;
    end
  end

  assign reuse_hit = reuse_valid_reg && (reuse_tag_reg == bus.req_addr[31:6]);
`else
  logic unused_fetch_done;

  assign unused_fetch_done = fetch_done;
  assign reuse_hit         = 1'b0;
`endif

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_addr  = base_reg;
  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_addr  = mem_addr_reg;

endmodule

// File: tb/tb_block_fill_responder.sv
// Directed-plus-random bench for block_fill_responder against a block-level reference model.
// Honours BLOCK_FILL_REUSE_EN when deciding whether a request should be served from the reuse entry.
module tb_block_fill_responder;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;

  always #5 clk_i = ~clk_i;

  block_fill_responder_if #(.BLOCK_BITS(512), .WORD_BITS(32)) bus ();

  block_fill_responder #(.BLOCK_BITS(512), .WORD_BITS(32)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] key;
  bit          model_tag_valid;
  logic [25:0] model_tag;
  logic [511:0] model_last;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_stalls(input int mode);
    if (mode == 3) return int'($urandom_range(2, 0));
    return mode;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_rsp_valid"}, 512'(bus.rsp_valid), 512'd0);
    check({tag, "_mem_req"},   512'(bus.mem_req),   512'd0);
    check({tag, "_mem_addr"},  512'(bus.mem_addr),  512'd0);
    check({tag, "_rsp_addr"},  512'(bus.rsp_addr),  512'd0);
    check({tag, "_rsp_data"},  bus.rsp_data,        512'd0);
  endtask

  // Asynchronous reset mid-cycle with a stray ack held high, then a quiet recovery.
  task automatic async_reset(input string tag);
    bus.mem_ack   = 1'b1;
    bus.req_valid = 1'b0;
    #2 rst_n_i = 1'b0;
    #1 check_all_zero(tag);
    model_tag_valid = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (2) begin
      @(negedge clk_i);
      check({tag, "_late_ack_ignored"}, 512'(bus.mem_req),   512'd0);
      check({tag, "_no_pulse"},         512'(bus.rsp_valid), 512'd0);
    end
    bus.mem_ack = 1'b0;
  endtask

  // One cache request. stall_mode: 0/2 fixed stalls per word, 3 random 0..2.
  // abort_after >= 0 resets the block once that many words have been captured.
  task automatic run_txn(input logic [31:0] addr, input int stall_mode, input bit hold,
                         input int abort_after);
    logic [31:0]  base;
    logic [511:0] exp_blk;
    bit           hit;
    bit           seen;
    int           words;
    int           stalls_left;
    int           total_stalls;
    int           edges;

    base = {addr[31:6], 6'h00};
`ifdef BLOCK_FILL_REUSE_EN
    hit = model_tag_valid && (model_tag == addr[31:6]);
`else
    hit = 1'b0;
`endif
    if (hit) exp_blk = model_last;
    else for (int j = 0; j < 16; j++) exp_blk[32*j +: 32] = (base + 32'(4*j)) ^ key;

    @(negedge clk_i);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.mem_ack   = 1'b0;
    @(posedge clk_i);

    words        = 0;
    total_stalls = 0;
    edges        = 0;
    seen         = 1'b0;
    stalls_left  = pick_stalls(stall_mode);
    while (!seen && edges < 200) begin
      @(negedge clk_i);
      if (abort_after >= 0 && words == abort_after) break;
      if (bus.rsp_valid) begin
        seen = 1'b1;
        check("latency",  512'(hit ? 0 : 16 + total_stalls), 512'(edges));
        check("words",    512'(words), 512'(hit ? 0 : 16));
        check("rsp_addr", 512'(bus.rsp_addr), 512'(base));
        check("rsp_data", bus.rsp_data, exp_blk);
        if (!hold) bus.req_valid = 1'b0;
        bus.mem_ack = 1'b0;
      end else if (bus.mem_req) begin
        check("mem_addr", 512'(bus.mem_addr), 512'(base + 32'(4*words)));
        if (stalls_left > 0) begin
          stalls_left--;
          total_stalls++;
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = $urandom;
        end else begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = (base + 32'(4*words)) ^ key;
          words++;
          stalls_left = pick_stalls(stall_mode);
        end
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
      end
      if (!seen) begin
        @(posedge clk_i);
        edges++;
      end
    end

    if (abort_after >= 0) begin
      check("abort_reached", 512'(words), 512'(abort_after));
      async_reset("midreset");
      return;
    end

    check("pulse_seen", 512'(seen), 512'd1);
    if (!seen) return;
    if (!hit) begin
      model_tag_valid = 1'b1;
      model_tag       = base[31:6];
      model_last      = exp_blk;
    end

    @(negedge clk_i);
    check("single_pulse", 512'(bus.rsp_valid), 512'd0);
    check("idle_no_req",  512'(bus.mem_req),   512'd0);
    @(negedge clk_i);
    if (!hold) begin
      check("no_refetch",     512'(bus.mem_req),   512'd0);
      check("no_second_rsp",  512'(bus.rsp_valid), 512'd0);
    end else begin
`ifdef BLOCK_FILL_REUSE_EN
      check("held_rehit_pulse", 512'(bus.rsp_valid), 512'd1);
      check("held_rehit_nomem", 512'(bus.mem_req),   512'd0);
`else
      check("held_refetch_req",  512'(bus.mem_req),  512'd1);
      check("held_refetch_addr", 512'(bus.mem_addr), 512'(base));
`endif
      async_reset("holdreset");
    end
  endtask

  initial begin
    logic [31:0] a;
    bus.req_valid   = 1'b0;
    bus.req_addr    = 32'd0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = 32'd0;
    key             = 32'hA5A5_0000;
    model_tag_valid = 1'b0;
    model_tag       = 26'd0;
    model_last      = 512'd0;

    repeat (2) @(negedge clk_i);
    check_all_zero("reset");
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);

    run_txn(32'h0000_1234, 0, 1'b0, -1);
    check("word3", 512'(bus.rsp_data[127:96]), 512'(32'hA5A5_120C));
    run_txn(32'h0000_1230, 0, 1'b0, -1);
    run_txn(32'h0000_1240, 0, 1'b0, -1);
    run_txn(32'h0000_1244, 0, 1'b0, -1);

    key = $urandom;
    run_txn(32'h3000_0000 | ($urandom & 32'h0000_FFFF), 2, 1'b0, -1);

    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(1, 0) == 1) key = $urandom;
      case ($urandom_range(2, 0))
        0:       a = 32'h0000_1200 | ($urandom & 32'h3F);
        1:       a = 32'h0000_1240 | ($urandom & 32'h3F);
        default: a = $urandom;
      endcase
      run_txn(a, 3, 1'b0, -1);
    end

    run_txn(32'h0000_0040, 0, 1'b1, -1);
    run_txn(32'h0000_1240, 0, 1'b0, 7);
    run_txn(32'h0000_0080, 0, 1'b0, -1);
    run_txn(32'hFFFF_FFC4, 3, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
